// File: rtl/data_memory_lsu.sv
// data_memory_lsu: RV32I byte/half/word load-store unit in front of a word-wide data array.
// A valid/ready request channel feeds a fixed-latency response strobe.
// Optional build macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned half/word
// accesses fail with resp_err. When it is undefined, the low address bits are ignored.
module data_memory_lsu #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_req_opcode,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_is_load;
    logic          w_is_store;
    logic          w_in_range;
    logic          w_size_ok;
    logic          w_misalign;
    logic          w_err;
    logic [1:0]    w_off;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load_data;
    logic [3:0]    w_wmask;
    logic [31:0]   w_wdata_sh;
    logic          w_commit;
    logic          w_we;

    assign o_req_ready = (r_state == StIdle);

    // Decode the latched request: legality, lane offset, load extension and store lanes.
    always_comb begin
        w_is_load   = (r_opcode == 7'b0000011);
        w_is_store  = (r_opcode == 7'b0100011);
        // Full 30-bit index compare so high addresses never alias into the array.
        w_in_range  = ({2'b00, r_addr[31:2]} < DEPTH_WORDS);
        w_size_ok   = 1'b0;
        if (w_is_load) begin
            w_size_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010) ||
                        (r_funct3 == 3'b100) || (r_funct3 == 3'b101);
        end else if (w_is_store) begin
            w_size_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_err = (w_is_load || w_is_store) && (!w_size_ok || !w_in_range || w_misalign);

        // Halfwords drop addr[0], words drop addr[1:0].
        unique case (r_funct3[1:0])
            2'b00:   w_off = r_addr[1:0];
            2'b01:   w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase

        w_idx     = r_addr[AW+1:2];
        w_rword   = r_mem[w_idx];
        w_shifted = w_rword >> {w_off, 3'b000};

        unique case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = w_shifted;
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = 32'd0;
        endcase

        unique case (r_funct3[1:0])
            2'b00:   w_wmask = 4'b0001 << w_off;
            2'b01:   w_wmask = 4'b0011 << w_off;
            2'b10:   w_wmask = 4'b1111;
            default: w_wmask = 4'b0000;
        endcase
        w_wdata_sh = r_wdata << {w_off, 3'b000};

        w_commit = (r_state == StWait) && (r_cnt == 4'd0);
        w_we     = w_commit && w_is_store && !w_err;
    end

    // Backing array: cleared on reset, byte-lane writes at the response edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with latched request and registered response outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_opcode     <= 7'd0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_resp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_opcode <= i_req_opcode;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        r_cnt    <= 4'(LATENCY - 1);
                        r_state  <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= StResp;
                        o_resp_valid <= 1'b1;
                        o_resp_err   <= w_err;
                        o_resp_rdata <= (w_is_load && !w_err) ? w_load_data : 32'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    o_resp_valid <= 1'b0;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
